// File: rtl/ascon_axil_master.sv
// ---------------------------------------------------------------------------
// ascon_axil_master
//
// Turns a simple valid/ready command port into single AXI4-Lite transactions
// and returns each result on a valid/ready response port. Only one
// transaction is in flight at a time.
//
// Ports
//   m00_axi_aclk, m00_axi_areset       clock, synchronous active-high reset
//   cmd_valid/ready, cmd_we, cmd_addr,
//   cmd_wdata, cmd_wstrb               command (we=1 write, we=0 read)
//   rsp_valid/ready, rsp_rdata,
//   rsp_resp                           response (rdata is 0 for writes)
//   m00_axi_aw*/w*/b*/ar*/r*           AXI4-Lite master channels
//
// Build option
//   ASCON_AXIL_MASTER_TIMEOUT_EN  when defined, a watchdog aborts a transaction
//   after TIMEOUT_CYCLES cycles in one bus state and answers SLVERR (2'b10).
//   When undefined the master waits forever and TIMEOUT_CYCLES is unused.
// ---------------------------------------------------------------------------
module ascon_axil_master #(
    parameter int C_M00_AXI_ADDR_WIDTH = 7,
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 256
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_areset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_we,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                          m00_axi_awprot,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                          m00_axi_arprot,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);

    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RSP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;

`ifdef ASCON_AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_we) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently, in either order or together.
                if (awvalid_q && m00_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m00_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)      state_d   = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m00_axi_bvalid) begin
                    resp_d  = m00_axi_bresp;
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (m00_axi_arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (m00_axi_rvalid) begin
                    rdata_d = m00_axi_rdata;
                    resp_d  = m00_axi_rresp;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ASCON_AXIL_MASTER_TIMEOUT_EN
        // Counter restarts whenever the state changes; it only runs while
        // the master is waiting on the bus.
        busy  = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
        cnt_d = '0;
        if (busy && (state_d == state_q)) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = S_RSP;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                rdata_d   = '0;
                resp_d    = 2'b10;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef ASCON_AXIL_MASTER_TIMEOUT_EN
    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) cnt_q <= '0;
        else                cnt_q <= cnt_d;
    end
`endif

    assign cmd_ready       = (state_q == S_IDLE);
    assign rsp_valid       = (state_q == S_RSP);
    assign rsp_rdata       = rdata_q;
    assign rsp_resp        = resp_q;

    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = (state_q == S_WR_RESP);
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = (state_q == S_RD_ADDR);
    assign m00_axi_rready  = (state_q == S_RD_DATA);

endmodule
